// File: rtl/alarm_set_ctrl.sv
// alarm_set_ctrl: debounced up/down/go keys edit the alarm value and launch the timer
// Optional key auto-repeat in IDLE is enabled by defining AUTO_REPEAT_EN.
module alarm_set_ctrl #(
    parameter logic [15:0] DEBOUNCE   = 16'd1000,
    parameter logic [7:0]  ALARM_MAX  = 8'd99,
    parameter logic [7:0]  ALARM_INIT = 8'd5,
    parameter logic [23:0] REPEAT_CYC = 24'd500000
) (
    input  logic       Clk,
    input  logic       rst_n,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_go,
    input  logic       pluse,
    output logic       start,
    output logic [7:0] alarm,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, START, RUN} state_t;
    state_t      state, state_n;
    logic [2:0]  raw, s1, s2, db, ev;
    logic [15:0] cnt [3];
    logic [7:0]  alarm_n;
    logic        up_e, dn_e, go_e;

    assign raw  = {key_go, key_down, key_up};
    assign go_e = ev[2];

    // press event is registered on the debounced 1->0 flip; releases are silent
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '1;
            s2 <= '1;
            db <= '1;
            ev <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 3; i++) begin
                ev[i] <= 1'b0;
                if (s2[i] == db[i]) cnt[i] <= '0;
                else if (cnt[i] == DEBOUNCE) begin
                    cnt[i] <= '0;
                    db[i]  <= s2[i];
                    ev[i]  <= ~s2[i];
                end else cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    logic [23:0] rep_cnt;
    logic        rep_ev, rep_run;

    // exactly one of up/down held low while idle keeps the repeat counter running
    assign rep_run = (state == IDLE) && (db[0] ^ db[1]);

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
            rep_ev  <= 1'b0;
        end else if (!rep_run) begin
            rep_cnt <= '0;
            rep_ev  <= 1'b0;
        end else if (rep_cnt == REPEAT_CYC - 24'd1) begin
            rep_cnt <= '0;
            rep_ev  <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + 24'd1;
            rep_ev  <= 1'b0;
        end
    end

    assign up_e = ev[0] | (rep_ev & ~db[0]);
    assign dn_e = ev[1] | (rep_ev & ~db[1]);
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYC;
    assign up_e = ev[0];
    assign dn_e = ev[1];
`endif

    always_comb begin
        state_n = state;
        alarm_n = alarm;
        case (state)
            IDLE: begin
                if (go_e) state_n = (alarm != 8'd0) ? START : IDLE;
                else if (up_e && !dn_e) alarm_n = (alarm == ALARM_MAX) ? 8'd0 : alarm + 8'd1;
                else if (dn_e && !up_e) alarm_n = (alarm == 8'd0) ? ALARM_MAX : alarm - 8'd1;
            end
            START:   state_n = RUN;
            RUN:     state_n = pluse ? IDLE : RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            alarm <= ALARM_INIT;
            start <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            alarm <= alarm_n;
            start <= (state_n == START);
            busy  <= (state_n != IDLE);
        end
    end
endmodule
